// File: rtl/modulation_segment_collector.sv
// Collects NUM_SEGS indexed segments for one symbol, then streams them out in index order.
// Define MOD_SEG_ERR_EN to add the sticky seg_err output (illegal or duplicate index seen).
module modulation_segment_collector #(
    parameter int NUM_SEGS = 8,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] segment_in,
    input  logic [IDX_W-1:0]  segment_idx,
    input  logic              segment_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              valid,
`ifdef MOD_SEG_ERR_EN
    output logic              seg_err,
`endif
    output logic              busy
);

    // Output handshake: a sample moves on every clk edge where sample_valid and
    // sample_ready are both high; sample_out/sample_valid never change while stalled.

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } state_t;

    localparam logic [IDX_W:0]   SEG_COUNT = (IDX_W + 1)'(NUM_SEGS);
    localparam logic [IDX_W-1:0] LAST_PTR  = IDX_W'(NUM_SEGS - 1);

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   seg_buf [NUM_SEGS];
    logic [NUM_SEGS-1:0] mask;
    logic [NUM_SEGS-1:0] mask_next;
    logic [NUM_SEGS-1:0] idx_onehot;
    logic [IDX_W-1:0]    rd_ptr;
    logic [DATA_W-1:0]   first_sample;
    logic                idx_legal;
    logic                seg_write;
    logic                collect_done;
    logic                transfer;
    logic                last_transfer;

    always_comb begin
        idx_legal     = {1'b0, segment_idx} < SEG_COUNT;
        seg_write     = (state == COLLECT) && segment_valid && idx_legal;
        idx_onehot    = seg_write ? (NUM_SEGS'(1) << segment_idx) : '0;
        mask_next     = mask | idx_onehot;
        collect_done  = (state == COLLECT) && (&mask_next);
        transfer      = (state == EMIT) && sample_valid && sample_ready;
        last_transfer = transfer && (rd_ptr == LAST_PTR);
        // Segment 0 may be arriving in the very cycle that completes the symbol.
        first_sample  = (seg_write && (segment_idx == '0)) ? segment_in : seg_buf[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                if (collect_done) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                busy = 1'b1;
                if (last_transfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (seg_write) begin
            seg_buf[segment_idx] <= segment_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask         <= '0;
            rd_ptr       <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            valid        <= 1'b0;
        end else begin
            valid <= last_transfer;
            if ((state == IDLE) && start) begin
                mask <= '0;
            end else if (seg_write) begin
                mask <= mask_next;
            end
            // Output register is preloaded with the next buffered entry so it is ready on transfer.
            if (collect_done) begin
                rd_ptr       <= '0;
                sample_out   <= first_sample;
                sample_valid <= 1'b1;
            end else if (last_transfer) begin
                rd_ptr       <= '0;
                sample_out   <= '0;
                sample_valid <= 1'b0;
            end else if (transfer) begin
                rd_ptr     <= rd_ptr + 1'b1;
                sample_out <= seg_buf[rd_ptr + 1'b1];
            end
        end
    end

`ifdef MOD_SEG_ERR_EN
    logic seg_fault;

    assign seg_fault = (state == COLLECT) && segment_valid &&
                       (!idx_legal || ((mask & idx_onehot) != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            seg_err <= 1'b0;
        end else if (seg_fault) begin
            seg_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_modulation_segment_collector.sv
// Bench for modulation_segment_collector: an 8-segment and a 6-segment instance share one
// input bus; a queue-based reference model derives each instance's expected sample stream.
module tb_modulation_segment_collector;

    localparam int DW = 32;
    localparam int NA = 8;
    localparam int NB = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          segment_valid;
    logic          sample_ready;
    logic [DW-1:0] segment_in;
    logic [2:0]    segment_idx;
    logic [DW-1:0] so [2];
    logic          sv [2];
    logic          vo [2];
    logic          bo [2];
`ifdef MOD_SEG_ERR_EN
    logic          eo [2];
`endif

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    modulation_segment_collector #(.NUM_SEGS(NA), .DATA_W(DW), .IDX_W(3)) dut_a (
        .clk(clk), .reset(reset), .start(start), .segment_in(segment_in),
        .segment_idx(segment_idx), .segment_valid(segment_valid),
        .sample_out(so[0]), .sample_valid(sv[0]), .sample_ready(sample_ready),
        .valid(vo[0]),
`ifdef MOD_SEG_ERR_EN
        .seg_err(eo[0]),
`endif
        .busy(bo[0]));

    modulation_segment_collector #(.NUM_SEGS(NB), .DATA_W(DW), .IDX_W(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .segment_in(segment_in),
        .segment_idx(segment_idx), .segment_valid(segment_valid),
        .sample_out(so[1]), .sample_valid(sv[1]), .sample_ready(sample_ready),
        .valid(vo[1]),
`ifdef MOD_SEG_ERR_EN
        .seg_err(eo[1]),
`endif
        .busy(bo[1]));

    function automatic int n_of(input int k);
        return (k == 0) ? NA : NB;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor: transfers, stalls, frame-done pulses ----------------
    logic [DW-1:0] obs [2][16];
    int            obs_cyc [2][16];
    int            obs_n [2]      = '{0, 0};
    int            vcount [2]     = '{0, 0};
    logic          stall [2]      = '{1'b0, 1'b0};
    logic [DW-1:0] stall_val [2]  = '{'0, '0};
    logic          prev_v [2]     = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (stall[k]) begin
                check($sformatf("hold_valid_n%0d", n_of(k)), DW'(sv[k]), DW'(1));
                check($sformatf("hold_data_n%0d", n_of(k)), so[k], stall_val[k]);
            end
            if (vo[k] === 1'b1) begin
                vcount[k]++;
                check($sformatf("valid_after_last_n%0d", n_of(k)), obs_n[k], n_of(k));
                check($sformatf("valid_one_cycle_n%0d", n_of(k)), DW'(prev_v[k]), DW'(0));
            end
            if ((sv[k] === 1'b1) && sample_ready && !reset) begin
                if (obs_n[k] < 16) begin
                    obs[k][obs_n[k]]     = so[k];
                    obs_cyc[k][obs_n[k]] = cycle;
                end
                obs_n[k]++;
            end
            stall[k]     = (sv[k] === 1'b1) && !sample_ready && !reset;
            stall_val[k] = so[k];
            prev_v[k]    = (vo[k] === 1'b1);
        end
    end

    // ---------------- ready driver ----------------
    int ready_mode  = 0;
    int ready_phase = 0;

    initial begin
        sample_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       sample_ready = 1'b1;
                1: begin
                    sample_ready = (ready_phase % 3 == 0);
                    ready_phase++;
                end
                default: sample_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- reference model ----------------
    int            pend_idx[$];
    logic [DW-1:0] pend_val[$];
    int            ev_idx[$];
    logic [DW-1:0] ev_val[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_err;

    // Replays the accepted events: the last write per index wins, collection stops once
    // every index 0..n-1 has been seen, and out-of-range or repeated indices flag an error.
    task automatic build_expected(input int n);
        logic [DW-1:0] val [16];
        bit            seen [16];
        int            got;
        got     = 0;
        exp_q   = {};
        exp_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            seen[i] = 1'b0;
            val[i]  = '0;
        end
        for (int e = 0; (e < ev_idx.size()) && (got < n); e++) begin
            if (ev_idx[e] >= n) begin
                exp_err = 1'b1;
            end else begin
                if (seen[ev_idx[e]]) exp_err = 1'b1;
                else got++;
                seen[ev_idx[e]] = 1'b1;
                val[ev_idx[e]]  = ev_val[e];
            end
        end
        for (int i = 0; i < n; i++) exp_q.push_back(val[i]);
    endtask

    task automatic push_ev(input int idx, input logic [DW-1:0] val);
        pend_idx.push_back(idx);
        pend_val.push_back(val);
    endtask

    task automatic send_pending(input bit gaps);
        for (int i = 0; i < pend_idx.size(); i++) begin
            segment_valid = 1'b1;
            segment_idx   = 3'(pend_idx[i]);
            segment_in    = pend_val[i];
            ev_idx.push_back(pend_idx[i]);
            ev_val.push_back(pend_val[i]);
            tick();
            segment_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    task automatic begin_frame(input int mode);
        ready_mode  = mode;
        ready_phase = 0;
        ev_idx      = {};
        ev_val      = {};
        for (int k = 0; k < 2; k++) begin
            obs_n[k]  = 0;
            vcount[k] = 0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy_after_start_n%0d", n_of(k)), DW'(bo[k]), DW'(1));
`ifdef MOD_SEG_ERR_EN
            check($sformatf("err_clear_on_start_n%0d", n_of(k)), DW'(eo[k]), DW'(0));
`endif
        end
    endtask

    task automatic run_frame(input string name, input bit gaps, input int mode, input bit extra_start);
        int t;
        begin_frame(mode);
        send_pending(gaps);
        if (extra_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        t = 0;
        while ((bo[0] || bo[1]) && (t < 300)) begin
            tick();
            t++;
        end
        check({name, "_done_in_time"}, DW'(t < 300), DW'(1));
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            int n;
            n = n_of(k);
            build_expected(n);
            check($sformatf("%s_count_n%0d", name, n), obs_n[k], n);
            for (int i = 0; (i < n) && (i < obs_n[k]) && (i < 16); i++)
                check($sformatf("%s_n%0d_sample%0d", name, n, i), obs[k][i], exp_q[i]);
            if ((mode == 0) && (obs_n[k] == n))
                check($sformatf("%s_throughput_n%0d", name, n), obs_cyc[k][n-1] - obs_cyc[k][0], n - 1);
            check($sformatf("%s_valid_pulses_n%0d", name, n), vcount[k], 1);
            check($sformatf("%s_busy_low_n%0d", name, n), DW'(bo[k]), DW'(0));
            check($sformatf("%s_sv_low_n%0d", name, n), DW'(sv[k]), DW'(0));
`ifdef MOD_SEG_ERR_EN
            check($sformatf("%s_seg_err_n%0d", name, n), DW'(eo[k]), DW'(exp_err));
`endif
        end
        pend_idx = {};
        pend_val = {};
    endtask

    task automatic check_idle_outputs(input string name);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_sample_out_n%0d", name, n_of(k)), so[k], '0);
            check($sformatf("%s_sample_valid_n%0d", name, n_of(k)), DW'(sv[k]), DW'(0));
            check($sformatf("%s_valid_n%0d", name, n_of(k)), DW'(vo[k]), DW'(0));
            check($sformatf("%s_busy_n%0d", name, n_of(k)), DW'(bo[k]), DW'(0));
`ifdef MOD_SEG_ERR_EN
            check($sformatf("%s_seg_err_n%0d", name, n_of(k)), DW'(eo[k]), DW'(0));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int perm [8];
        reset         = 1'b1;
        start         = 1'b0;
        segment_valid = 1'b0;
        segment_idx   = '0;
        segment_in    = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_idle_outputs("reset");

        for (int i = 0; i < 8; i++) push_ev(i, DW'(32'h100 + i));
        run_frame("basic", 1'b0, 0, 1'b0);

        perm = '{7, 3, 0, 5, 1, 6, 2, 4};
        for (int i = 0; i < 8; i++) push_ev(perm[i], DW'(32'hA0 + perm[i]));
        run_frame("ooo", 1'b0, 0, 1'b0);

        for (int i = 0; i < 8; i++) push_ev(i, $urandom);
        run_frame("bp", 1'b0, 1, 1'b0);

        push_ev(0, 32'h100);
        push_ev(1, 32'h101);
        push_ev(2, 32'h11);
        push_ev(2, 32'h22);
        for (int i = 3; i < 8; i++) push_ev(i, DW'(32'h100 + i));
        run_frame("dup", 1'b0, 0, 1'b0);
        repeat (4) tick();
`ifdef MOD_SEG_ERR_EN
        check("dup_err_sticky_n6", DW'(eo[1]), DW'(1));
`endif

        // Abort a symbol part-way through collection.
        begin_frame(0);
        for (int i = 0; i < 4; i++) push_ev(i, $urandom);
        send_pending(1'b0);
        pend_idx = {};
        pend_val = {};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("abort");
        repeat (6) tick();
        check("abort_no_valid_n8", vcount[0], 0);
        check("abort_no_valid_n6", vcount[1], 0);

        // Index 0 last so both instances enter EMIT together; a start lands during EMIT.
        for (int i = 1; i < 8; i++) push_ev(i, $urandom);
        push_ev(0, $urandom);
        run_frame("restart", 1'b0, 1, 1'b1);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                int j;
                int tmp;
                j       = $urandom_range(0, i);
                tmp     = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            for (int i = 0; i < 8; i++) push_ev(perm[i], $urandom);
            repeat ($urandom_range(0, 3)) begin
                int pos;
                pos = $urandom_range(0, pend_idx.size());
                pend_idx.insert(pos, $urandom_range(0, 7));
                pend_val.insert(pos, $urandom);
            end
            run_frame($sformatf("rand%0d", f), 1'b1, 2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modulation_segment_collector.md
Name: modulation_segment_collector

Overview:
- Downstream stage of the per-segment else-calculation blocks in the modulation pipe.
- Each upstream stage produces one delayed segment value. The segments arrive serially on a shared bus, tagged with their index, and are buffered here.
- Once all NUM_SEGS segments of a symbol are present, the block streams them out in index order (0 first) over a valid/ready handshake, then signals frame completion.

Parameters:
- NUM_SEGS, 8, number of segments per modulated symbol (2..16)
- DATA_W, 32, width of segment values and output samples
- IDX_W, 3, width of segment index; must equal clog2(NUM_SEGS)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins collection of a new symbol
- segment_in  input  DATA_W  segment value from the upstream stage
- segment_idx  input  IDX_W  index of segment_in
- segment_valid  input  1  segment_in/segment_idx qualifier
- sample_out  output  DATA_W  buffered segment being emitted
- sample_valid  output  1  sample_out is valid
- sample_ready  input  1  downstream accepts sample_out
- valid  output  1  one-cycle pulse when the last sample of the symbol is accepted
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (reset high at a clk edge):
  - state=IDLE; received mask cleared; read pointer=0.
  - sample_out=0, sample_valid=0, valid=0, busy=0.
  - Buffer contents are don't-care after reset.
  - Reset mid-collection or mid-emission aborts the symbol with no valid pulse.
- IDLE:
  - start=1 -> COLLECT next cycle; mask cleared.
  - segment_valid is ignored.
- COLLECT:
  - segment_valid=1 with segment_idx<NUM_SEGS -> buf[idx]<=segment_in; mask[idx]<=1.
  - Duplicate index overwrites the buffered value and is counted once.
  - segment_idx>=NUM_SEGS is dropped.
  - When the mask becomes all-ones (including the write in the current cycle) -> EMIT next cycle with rd_ptr=0.
  - Minimum collection latency: NUM_SEGS cycles after entering COLLECT.
- EMIT:
  - sample_valid=1 and sample_out=buf[rd_ptr], registered, so they are stable while sample_ready=0.
  - Transfer occurs on a cycle with sample_valid and sample_ready both high.
  - On transfer with rd_ptr<NUM_SEGS-1: rd_ptr increments.
  - On transfer with rd_ptr==NUM_SEGS-1: next cycle is IDLE with sample_valid=0 and valid=1 for exactly one cycle.
  - With continuous ready, throughput is one sample per cycle.
  - segment_valid is ignored in EMIT.
- start while busy=1 is ignored; there is no restart.
- start and the final sample acceptance in the same cycle: start is ignored, because the state is still EMIT in that cycle.
- busy is combinational from state: 1 in COLLECT and EMIT.
- No arithmetic: sample_out is a bit-exact copy of the buffered segment.

Optional Feature:
- Macro: MOD_SEG_ERR_EN.
- When defined:
  - Adds output port seg_err (1 bit).
  - seg_err is sticky and is set on the cycle after either of these events in COLLECT: segment_idx>=NUM_SEGS with segment_valid, or a duplicate index.
  - Cleared only by reset or by start accepted in IDLE.
  - Reset value 0.
  - Data-path behaviour is unchanged.
- When undefined: no seg_err port, and the error logic is absent.

Test Plan:
- Basic frame, NUM_SEGS=8:
  - Stimulus: reset; start; segments idx 0..7 with values 0x100+idx on consecutive cycles; sample_ready held high.
  - Required: busy high from the cycle after start; samples 0x100..0x107 on 8 consecutive cycles in order; valid pulses once after 0x107; busy low after.
- Out-of-order arrival:
  - Stimulus: indices 7,3,0,5,1,6,2,4 with values 0xA0+idx.
  - Required: emission order is 0xA0..0xA7.
- Backpressure:
  - Stimulus: sample_ready toggled 1,0,0,1,...
  - Required: sample_out holds steady while ready=0; exactly 8 transfers; no sample lost or duplicated; valid pulses only after the 8th transfer.
- Duplicate and illegal index:
  - Stimulus: idx 2 sent with 0x11 then 0x22; with NUM_SEGS=6, idx 7 sent.
  - Required: emitted sample 2 = 0x22; idx 7 dropped; with MOD_SEG_ERR_EN, seg_err=1 until the next start.
- Reset and start-while-busy:
  - Stimulus: reset asserted after 4 segments; then start and a full frame, with an extra start issued during EMIT.
  - Required: after reset, outputs are all 0 and no valid pulse; the new frame completes normally; the extra start has no effect.
